// File: rtl/pixel_readout_framer.sv
// rtl/pixel_readout_framer.sv - tags sensor pixels with sof/eol/eof and buffers them onto a ready/valid stream
module pixel_readout_framer #(
    parameter int PIXEL_ARRAY_WIDTH  = 128,
    parameter int PIXEL_ARRAY_HEIGHT = 128,
    parameter int PIXEL_BITS         = 8,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [PIXEL_BITS-1:0] pix_data,
    input  logic                  pix_frame_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIXEL_BITS-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  overflow,
    output logic                  frame_error,
    input  logic                  clear_flags,
    output logic [15:0]           frame_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int EW = PIXEL_BITS + 3;
    localparam logic [CW-1:0] COL_LAST   = CW'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DROP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] col, col_cur;
    logic [RW-1:0] row, row_cur;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;
    logic          accept, full, push, pop, tag_eol, tag_eof;
    logic          ovf_set, ferr_set;

    // A frame-start pixel is always position (0,0), whatever the counters hold.
    always_comb begin
        accept   = pix_valid && (pix_frame_start || state == ACTIVE);
        col_cur  = pix_frame_start ? '0 : col;
        row_cur  = pix_frame_start ? '0 : row;
        tag_eol  = (col_cur == COL_LAST);
        tag_eof  = tag_eol && (row_cur == ROW_LAST);
        full     = (count == COUNT_FULL);
        push     = accept && !full;
        out_valid = (count != '0);
        pop      = out_valid && out_ready;
        ovf_set  = accept && full;
        ferr_set = pix_valid && pix_frame_start && (state == ACTIVE);
        head     = mem[rd_ptr];
        out_data = out_valid ? head[PIXEL_BITS-1:0] : '0;
        out_eof  = out_valid && head[PIXEL_BITS];
        out_eol  = out_valid && head[PIXEL_BITS+1];
        out_sof  = out_valid && head[PIXEL_BITS+2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else if (accept) begin
            if (full) begin
                state <= DROP;
            end else if (tag_eof) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
            end else begin
                state <= ACTIVE;
                if (tag_eol) begin
                    col <= '0;
                    row <= row_cur + RW'(1);
                end else begin
                    col <= col_cur + CW'(1);
                    row <= row_cur;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pix_frame_start, tag_eol, tag_eof, pix_data};
        end
    end

    // Fullness uses the registered count, so a same-cycle pop never makes room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            overflow    <= ovf_set  | (overflow    & ~clear_flags);
            frame_error <= ferr_set | (frame_error & ~clear_flags);
            if (pop && out_eof) frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_pixel_readout_framer.sv
// tb/tb_pixel_readout_framer.sv - table-driven directed bench for pixel_readout_framer
module tb_pixel_readout_framer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       pix_frame_start = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_flags = 1'b0;
    logic       out_valid, out_sof, out_eol, out_eof, overflow, frame_error;
    logic [7:0] out_data;
    logic [15:0] frame_count;
    logic       b_valid, b_sof, b_eol, b_eof, b_overflow, b_frame_error;
    logic [7:0] b_data;
    logic [15:0] b_frame_count;

    pixel_readout_framer #(.PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(2), .PIXEL_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_frame_start(pix_frame_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .overflow(overflow), .frame_error(frame_error), .clear_flags(clear_flags),
        .frame_count(frame_count));

    pixel_readout_framer #(.PIXEL_ARRAY_WIDTH(128), .PIXEL_ARRAY_HEIGHT(128), .PIXEL_BITS(8), .FIFO_DEPTH(16)) big (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_frame_start(pix_frame_start), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_sof(b_sof), .out_eol(b_eol), .out_eof(b_eof),
        .overflow(b_overflow), .frame_error(b_frame_error), .clear_flags(clear_flags),
        .frame_count(b_frame_count));

    always #5 clk = ~clk;

    typedef struct {
        logic       fs;
        logic [7:0] d;
        logic       kept;
        logic [2:0] tags;
    } vec_t;

    vec_t        tab[$];
    logic [10:0] got[$];
    logic [10:0] held;
    logic        held_v = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: records every pop, and checks the head holds still across a stall.
    always @(negedge clk) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("stall_hold", {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, held});
            if (out_valid && out_ready) got.push_back({out_data, out_sof, out_eol, out_eof});
            held_v = out_valid && !out_ready;
            held   = {out_data, out_sof, out_eol, out_eof};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pix_valid = 1'b0;
        pix_frame_start = 1'b0;
        clear_flags = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        got.delete();
        tab.delete();
    endtask

    task automatic add(input logic fs, input logic [7:0] d, input logic kept, input logic [2:0] tags);
        vec_t v;
        v.fs = fs; v.d = d; v.kept = kept; v.tags = tags;
        tab.push_back(v);
    endtask

    // Hand tag table for a 4x2 frame: eol at col 3, eof at the last pixel.
    task automatic add_frame(input logic [7:0] base);
        add(1'b1, base,        1'b1, 3'b100);
        add(1'b0, base + 8'd1, 1'b1, 3'b000);
        add(1'b0, base + 8'd2, 1'b1, 3'b000);
        add(1'b0, base + 8'd3, 1'b1, 3'b010);
        add(1'b0, base + 8'd4, 1'b1, 3'b000);
        add(1'b0, base + 8'd5, 1'b1, 3'b000);
        add(1'b0, base + 8'd6, 1'b1, 3'b000);
        add(1'b0, base + 8'd7, 1'b1, 3'b011);
    endtask

    task automatic pix(input logic fs, input logic [7:0] d);
        pix_valid = 1'b1;
        pix_frame_start = fs;
        pix_data = d;
        step();
        pix_valid = 1'b0;
        pix_frame_start = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && out_valid; k++) step();
        chk("drain_done", out_valid, 1'b0);
    endtask

    task automatic compare_got(input string name);
        int n;
        n = 0;
        foreach (tab[i]) begin
            if (tab[i].kept) begin
                if (n < got.size()) chk(name, got[n], {tab[i].d, tab[i].tags});
                n++;
            end
        end
        chk({name, "_len"}, got.size(), n);
        got.delete();
        tab.delete();
    endtask

    task automatic run_tab(input string name, input int gap, input logic tog);
        foreach (tab[i]) begin
            if (tog) out_ready = ~out_ready;
            pix(tab[i].fs, tab[i].d);
            for (int g = 0; g < gap; g++) begin
                if (tog) out_ready = ~out_ready;
                step();
            end
        end
        drain();
        compare_got(name);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", {out_data, out_sof, out_eol, out_eof}, 11'h0);
        chk("rst_flags", {overflow, frame_error}, 2'b00);
        chk("rst_fcount", frame_count, 16'd0);

        // 1: basic frame
        add_frame(8'h10);
        run_tab("basic", 0, 1'b0);
        chk("basic_fcount", frame_count, 16'd1);
        chk("basic_flags", {overflow, frame_error}, 2'b00);

        // 2: pixels before the first frame start are dropped
        do_reset();
        add(1'b0, 8'hA0, 1'b0, 3'b000);
        add(1'b0, 8'hA1, 1'b0, 3'b000);
        add(1'b0, 8'hA2, 1'b0, 3'b000);
        add_frame(8'h20);
        run_tab("presync", 0, 1'b0);
        chk("presync_fcount", frame_count, 16'd1);

        // 3: overflow then resync
        do_reset();
        out_ready = 1'b0;
        pix(1'b1, 8'h10);
        for (int i = 1; i < 5; i++) pix(1'b0, 8'h10 + 8'(i));
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full", out_valid, 1'b1);
        for (int i = 5; i < 8; i++) pix(1'b0, 8'h10 + 8'(i));
        add(1'b0, 8'h10, 1'b1, 3'b100);
        add(1'b0, 8'h11, 1'b1, 3'b000);
        add(1'b0, 8'h12, 1'b1, 3'b000);
        add(1'b0, 8'h13, 1'b1, 3'b010);
        drain();
        compare_got("ovf_drain");
        chk("ovf_fcount0", frame_count, 16'd0);
        add_frame(8'h30);
        run_tab("ovf_resync", 0, 1'b0);
        chk("ovf_fcount1", frame_count, 16'd1);
        chk("ovf_sticky", overflow, 1'b1);

        // 4: mid-frame restart
        do_reset();
        add(1'b1, 8'h40, 1'b1, 3'b100);
        add(1'b0, 8'h41, 1'b1, 3'b000);
        add(1'b0, 8'h42, 1'b1, 3'b000);
        add(1'b0, 8'h43, 1'b1, 3'b010);
        add(1'b0, 8'h44, 1'b1, 3'b000);
        add_frame(8'h50);
        run_tab("restart", 0, 1'b0);
        chk("restart_ferr", frame_error, 1'b1);
        chk("restart_ovf", overflow, 1'b0);
        chk("restart_fcount", frame_count, 16'd1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clear_ferr", frame_error, 1'b0);
        pix(1'b1, 8'h60);
        clear_flags = 1'b1;
        pix(1'b1, 8'h61);
        clear_flags = 1'b0;
        chk("set_beats_clear", frame_error, 1'b1);
        drain();
        got.delete();

        // 5: toggling backpressure
        do_reset();
        add_frame(8'h90);
        run_tab("backpressure", 1, 1'b1);
        chk("bp_fcount", frame_count, 16'd1);
        chk("bp_flags", {overflow, frame_error}, 2'b00);

        // 5b: three back-to-back 128x128 frames into the 16-deep instance
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16384; i++) begin
                pix_valid = 1'b1;
                pix_frame_start = (i == 0);
                pix_data = 8'(i);
                step();
            end
        end
        pix_valid = 1'b0;
        pix_frame_start = 1'b0;
        for (int k = 0; k < 40 && b_valid; k++) step();
        chk("big_fcount", b_frame_count, 16'd3);
        chk("big_flags", {b_overflow, b_frame_error}, 2'b00);
        chk("big_empty", b_valid, 1'b0);
        got.delete();

        // 6: asynchronous reset with three entries held
        do_reset();
        add_frame(8'h10);
        run_tab("pre_async", 0, 1'b0);
        out_ready = 1'b0;
        pix(1'b1, 8'hB0);
        for (int i = 1; i < 5; i++) pix(1'b0, 8'hB0 + 8'(i));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_async_ovf", overflow, 1'b1);
        chk("pre_async_fcount", frame_count, 16'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_ovf", overflow, 1'b0);
        chk("async_fcount", frame_count, 16'd0);
        chk("async_data", out_data, 8'h00);
        #2;
        reset = 1'b1;
        step();
        got.delete();
        tab.delete();
        out_ready = 1'b1;
        add_frame(8'hC0);
        run_tab("post_async", 0, 1'b0);
        chk("post_async_fcount", frame_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_readout_framer.md
Name: pixel_readout_framer

Overview:
Downstream consumer of sensor_top pixel readout. Accepts the non-stallable per-pixel stream from the ADC/readout stage and tags each pixel with start-of-frame, end-of-line and end-of-frame markers. Buffers the tagged pixels in a FIFO and presents them on a ready/valid stream to the output interface.
Detects overflow and mid-frame restarts, and resynchronises on the next frame start.

Parameters:
PIXEL_ARRAY_WIDTH, 128, pixels per row (>=2)
PIXEL_ARRAY_HEIGHT, 128, rows per frame (>=1)
PIXEL_BITS, 8, pixel data width
FIFO_DEPTH, 16, entries, power of 2, >=2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pix_valid  in  1  pixel present this cycle; no backpressure upstream
pix_data  in  PIXEL_BITS  pixel value
pix_frame_start  in  1  qualifies pix_valid: this pixel is (row 0, col 0) of a new frame
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid && out_ready
out_data  out  PIXEL_BITS  head pixel value
out_sof  out  1  head is first pixel of frame
out_eol  out  1  head is last pixel of a row
out_eof  out  1  head is last pixel of frame
overflow  out  1  sticky: pixel lost to full FIFO
frame_error  out  1  sticky: frame_start arrived while a frame was active
clear_flags  in  1  synchronous clear of overflow and frame_error
frame_count  out  16  count of eof pixels popped, wraps at 2^16

Behaviour:
- Reset (reset=0, async): state=IDLE; col/row counters=0; FIFO empty; out_valid=0; out_data/out_sof/out_eol/out_eof=0; overflow=0; frame_error=0; frame_count=0.
- Input FSM:
  - IDLE: pix_valid without frame_start is discarded silently. pix_valid&&frame_start -> accept as (0,0), go ACTIVE.
  - ACTIVE: each pix_valid is accepted at current (row,col). col increments; at col=W-1 it wraps to 0 and row increments. The accepted pixel at (H-1,W-1) returns to IDLE.
  - DROP: all pixels discarded until pix_valid&&frame_start, which is accepted as (0,0) and goes to ACTIVE.
- Tags are computed on the input side and stored with the data, so the FIFO entry width is PIXEL_BITS+3:
  - sof = frame_start
  - eol = (col==W-1)
  - eof = (col==W-1 && row==H-1)
- frame_start in ACTIVE: frame_error<=1. The previous frame is truncated with no eof emitted. The pixel is accepted as (0,0) and the state stays ACTIVE.
- FIFO write: an accepted pixel is written iff count<FIFO_DEPTH, using the registered count.
  - A pop in the same cycle does NOT free space for the write.
  - If full: pixel lost, overflow<=1, state<=DROP. This applies even to the (H-1,W-1) pixel and to a frame_start pixel.
- FIFO read: first-word fall-through. out_valid = (count!=0); out_* = head entry, combinational from registered storage.
  - Pop on out_valid&&out_ready; pop while empty is ignored.
  - Simultaneous push+pop leaves count unchanged.
- Latency: a pixel written at edge N is visible at the head (if the FIFO was empty) after edge N. Throughput is 1 pixel/cycle both sides.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap; count is log2(FIFO_DEPTH)+1 bits.
- frame_count increments on a pop with out_eof=1.
- clear_flags=1 clears both sticky flags that cycle. A new set event in the same cycle wins (flag ends at 1).
- Reset mid-frame discards FIFO contents and in-progress frame immediately; out_valid drops asynchronously.
- Output stalls (out_ready=0) hold out_data and tags stable while out_valid=1.

Test Plan:
(Bench uses W=4, H=2, FIFO_DEPTH=4 unless noted.)
1. Basic frame: reset; 8 consecutive pixels 0x10..0x17, first with frame_start; out_ready=1 -> 8 outputs in order.
   - sof only on 0x10; eol on 0x13 and 0x17; eof only on 0x17.
   - frame_count=1; flags 0.
2. Pre-sync discard: 3 pix_valid without frame_start after reset, then a full frame -> only the frame's 8 pixels appear; first output has sof=1.
3. Overflow: out_ready=0, feed 5 pixels of a frame.
   - 4 stored; overflow=1; state DROP.
   - Remaining 3 pixels ignored; out_ready=1 drains exactly 4 (0x10..0x13), frame_count=0.
   - Next frame_start frame passes intact; frame_count=1.
4. Mid-frame restart: frame_start, 5 pixels, then frame_start with 8 more -> frame_error=1.
   - Output: 5 truncated pixels (no eof), then a full tagged frame; frame_count=1.
   - clear_flags -> frame_error=0.
5. Backpressure, full FIFO: toggle out_ready every cycle during a frame.
   - out_data stable while stalled; no loss; correct tags.
   - With FIFO_DEPTH=16, W=H=128, 3 back-to-back frames with out_ready=1 -> frame_count=3, no flags.
6. Async reset mid-frame: assert reset=0 between clock edges with FIFO holding 3 entries.
   - out_valid=0 and overflow=0 immediately; frame_count=0.
   - After release, a new frame streams correctly.
